// File: rtl/fetch_step_sequencer.sv
// fetch_step_sequencer
//
// Control-step sequencer for the datapath. It produces the fetch strobes
// itself (T0, T1 with a wait on memory, T2), then walks a variable-length
// execute phase one step per cycle. Each execute step appears as one bit of
// exec_step. The decode logic ANDs those bits with the opcode decode to form
// the datapath enables.
//
// Parameters
//   MAX_EXEC_STEPS  maximum execute steps per instruction (1..16); width of exec_step
//   STEP_W          width of exec_len and of the step index (2**STEP_W >= MAX_EXEC_STEPS)
//   ICOUNT_W        width of the retired-instruction counter
//
// Ports
//   Clock        system clock, rising edge
//   Clear        asynchronous active-high reset
//   run          level; keeps the sequencer fetching
//   halt_req     level; honoured only at an instruction boundary (or in IDLE)
//   mem_ready    memory read data valid, sampled in T1
//   stall        freezes the execute step while high
//   exec_len     number of execute steps of the instruction in IR, sampled in T2
//   PCout, MAR_enable, IncPC, ZLowIn      T0 strobes
//   MDR_read, MDR_enable, ZLowout         T1 strobes
//   PC_enable                             T1 strobe, only on the completing T1 cycle
//   MDRout, IR_enable                     T2 strobes
//   exec_step    one-hot execute step; bit k is step T(3+k)
//   instr_done   one-cycle pulse on the last execute step (or in T2 when exec_len=0)
//   halted       high in HALT
//   fetch_wait   high while T1 waits on mem_ready
//   icount       retired-instruction counter (wraps)

module fetch_step_sequencer #(
    parameter int MAX_EXEC_STEPS = 8,
    parameter int STEP_W         = 4,
    parameter int ICOUNT_W       = 16
) (
    input  logic                      Clock,
    input  logic                      Clear,
    input  logic                      run,
    input  logic                      halt_req,
    input  logic                      mem_ready,
    input  logic                      stall,
    input  logic [STEP_W-1:0]         exec_len,
    output logic                      PCout,
    output logic                      MAR_enable,
    output logic                      IncPC,
    output logic                      ZLowIn,
    output logic                      MDR_read,
    output logic                      MDR_enable,
    output logic                      ZLowout,
    output logic                      PC_enable,
    output logic                      MDRout,
    output logic                      IR_enable,
    output logic [MAX_EXEC_STEPS-1:0] exec_step,
    output logic                      instr_done,
    output logic                      halted,
    output logic                      fetch_wait,
    output logic [ICOUNT_W-1:0]       icount
);

    typedef enum logic [2:0] {
        IDLE,
        T0,
        T1,
        T2,
        EXEC,
        HALT
    } state_t;

    localparam logic [STEP_W:0] MAX_LEN = (STEP_W+1)'(MAX_EXEC_STEPS);

    state_t              state;
    state_t              boundary_next;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   last_step;
    logic [STEP_W:0]     len_ext;
    logic [STEP_W:0]     len_clamped;
    logic [STEP_W-1:0]   new_last;
    logic                at_last;
    logic                boundary;

    // Work out the index of the final execute step for the instruction now in
    // IR. Over-long requests are clamped to the largest supported length. The
    // value is only used when exec_len is non-zero, so the wrap for zero is harmless.
    // The extra bit on len_ext lets MAX_EXEC_STEPS=16 be represented even when
    // STEP_W is only 4.
    always_comb begin
        len_ext     = {1'b0, exec_len};
        len_clamped = (len_ext > MAX_LEN) ? MAX_LEN : len_ext;
        new_last    = STEP_W'(len_clamped - (STEP_W+1)'(1));
    end

    // The instruction boundary is the cycle that carries instr_done. That is T2
    // for a zero-length instruction, or the final execute step with no stall.
    // stall has to gate this cycle directly: otherwise a stall on the final step
    // could not hold back instr_done in that same cycle. At the boundary,
    // halt_req wins over run, and run alone goes straight back to T0 with no
    // bubble.
    always_comb begin
        at_last       = (step == last_step);
        boundary      = ((state == T2) && (exec_len == '0)) ||
                        ((state == EXEC) && !stall && at_last);
        boundary_next = halt_req ? HALT : (run ? T0 : IDLE);
    end

    // Main sequencer: state, execute step index, latched final step and the
    // retired count. Clear aborts whatever is in flight with nothing retired.
    // run and halt_req are looked at only in IDLE, in HALT and at the boundary,
    // so changing them mid-instruction has no effect.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state     <= IDLE;
            step      <= '0;
            last_step <= '0;
            icount    <= '0;
        end else begin
            if (boundary) begin
                icount <= icount + ICOUNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (halt_req) begin
                        state <= HALT;
                    end else if (run) begin
                        state <= T0;
                    end
                end
                T0: begin
                    state <= T1;
                end
                T1: begin
                    if (mem_ready) begin
                        state <= T2;
                    end
                end
                T2: begin
                    if (exec_len == '0) begin
                        state <= boundary_next;
                    end else begin
                        state     <= EXEC;
                        step      <= '0;
                        last_step <= new_last;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        if (at_last) begin
                            state <= boundary_next;
                            step  <= '0;
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end
                end
                HALT: begin
                    if (!halt_req && run) begin
                        state <= T0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobe decode. Everything comes from the state register and the step
    // index, except three outputs. PC_enable and fetch_wait also use mem_ready.
    // instr_done also uses the boundary condition above. When Clear forces the
    // state to IDLE, every output drops at once.
    always_comb begin
        PCout      = (state == T0);
        MAR_enable = (state == T0);
        IncPC      = (state == T0);
        ZLowIn     = (state == T0);
        MDR_read   = (state == T1);
        MDR_enable = (state == T1);
        ZLowout    = (state == T1);
        PC_enable  = (state == T1) && mem_ready;
        fetch_wait = (state == T1) && !mem_ready;
        MDRout     = (state == T2);
        IR_enable  = (state == T2);
        halted     = (state == HALT);
        instr_done = boundary;
        exec_step  = '0;
        if (state == EXEC) begin
            exec_step = MAX_EXEC_STEPS'(1) << step;
        end
    end

endmodule

// File: tb/tb_fetch_step_sequencer.sv
// tb_fetch_step_sequencer
//
// Bench for fetch_step_sequencer (MAX_EXEC_STEPS=8, STEP_W=4, ICOUNT_W=2).
// A driver issues one cycle of inputs at a time. For each cycle it pushes the
// output word expected from the sequencing rules into a queue. The monitor
// samples the DUT on each falling edge and checks it against the queue.

module tb_fetch_step_sequencer;

    localparam int MAXS = 8;
    localparam int SW   = 4;
    localparam int ICW  = 2;

    typedef struct {
        logic [22:0] vec;
        int          phase;
        int          seq;
    } exp_t;

    logic            Clock;
    logic            Clear;
    logic            run;
    logic            halt_req;
    logic            mem_ready;
    logic            stall;
    logic [SW-1:0]   exec_len;
    logic            PCout, MAR_enable, IncPC, ZLowIn;
    logic            MDR_read, MDR_enable, ZLowout, PC_enable;
    logic            MDRout, IR_enable;
    logic [MAXS-1:0] exec_step;
    logic            instr_done, halted, fetch_wait;
    logic [ICW-1:0]  icount;
    logic [22:0]     dut_vec;

    exp_t            exp_q[$];
    int              compared;
    int              mismatched;
    int              model_count;
    int              seq_no;

    fetch_step_sequencer #(
        .MAX_EXEC_STEPS(MAXS),
        .STEP_W        (SW),
        .ICOUNT_W      (ICW)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .run       (run),
        .halt_req  (halt_req),
        .mem_ready (mem_ready),
        .stall     (stall),
        .exec_len  (exec_len),
        .PCout     (PCout),
        .MAR_enable(MAR_enable),
        .IncPC     (IncPC),
        .ZLowIn    (ZLowIn),
        .MDR_read  (MDR_read),
        .MDR_enable(MDR_enable),
        .ZLowout   (ZLowout),
        .PC_enable (PC_enable),
        .MDRout    (MDRout),
        .IR_enable (IR_enable),
        .exec_step (exec_step),
        .instr_done(instr_done),
        .halted    (halted),
        .fetch_wait(fetch_wait),
        .icount    (icount)
    );

    assign dut_vec = {PCout, MAR_enable, IncPC, ZLowIn,
                      MDR_read, MDR_enable, ZLowout, PC_enable,
                      MDRout, IR_enable, exec_step,
                      instr_done, halted, fetch_wait, icount};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Phase codes: 0 idle, 1 T0, 2 T1, 3 T2, 4 execute step k, 5 halt.
    function automatic logic [22:0] expVec(input int phase, input int k,
                                           input bit ready, input bit done,
                                           input int cnt);
        logic [22:0] v;
        v = '0;
        case (phase)
            1: v[22:19] = 4'hF;
            2: begin
                v[18:16] = 3'b111;
                v[15]    = ready;
                v[2]     = !ready;
            end
            3: begin
                v[14:13] = 2'b11;
                v[4]     = done;
            end
            4: begin
                v[5+k] = 1'b1;
                v[4]   = done;
            end
            5: v[3] = 1'b1;
            default: v = '0;
        endcase
        v[1:0] = 2'(cnt % (1 << ICW));
        return v;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [SW-1:0] r4();
        return SW'($urandom_range(0, 15));
    endfunction

    task automatic checkOutput(input string name, input logic [22:0] act,
                               input logic [22:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle: drive the inputs just after the rising edge and queue
    // what the outputs must show during that cycle.
    task automatic applyStimulus(input bit r, input bit h, input bit mr, input bit st,
                                 input logic [SW-1:0] len, input int phase,
                                 input int k, input bit ready, input bit done);
        exp_t e;
        @(posedge Clock);
        #1;
        run       = r;
        halt_req  = h;
        mem_ready = mr;
        stall     = st;
        exec_len  = len;
        e.vec   = expVec(phase, k, ready, done, model_count);
        e.phase = phase;
        e.seq   = seq_no;
        seq_no++;
        exp_q.push_back(e);
    endtask

    // One whole instruction starting in T0. run and halt_req are randomised
    // everywhere except the boundary cycle, where b_run and b_halt are driven.
    task automatic doInstruction(input int waits, input int len, input int stall_step,
                                 input int stall_cycles, input bit rand_stalls,
                                 input bit b_halt, input bit b_run);
        int n;
        int s;
        applyStimulus(rb(), rb(), rb(), rb(), r4(), 1, 0, 1'b0, 1'b0);
        for (int w = 0; w < waits; w++) begin
            applyStimulus(rb(), rb(), 1'b0, rb(), r4(), 2, 0, 1'b0, 1'b0);
        end
        applyStimulus(rb(), rb(), 1'b1, rb(), r4(), 2, 0, 1'b1, 1'b0);
        if (len == 0) begin
            applyStimulus(b_run, b_halt, rb(), rb(), SW'(0), 3, 0, 1'b0, 1'b1);
            model_count++;
            return;
        end
        applyStimulus(rb(), rb(), rb(), rb(), SW'(len), 3, 0, 1'b0, 1'b0);
        n = (len > MAXS) ? MAXS : len;
        for (int k = 0; k < n; k++) begin
            if (k == stall_step) begin
                s = stall_cycles;
            end else if (rand_stalls && $urandom_range(0, 3) == 0) begin
                s = int'($urandom_range(1, 2));
            end else begin
                s = 0;
            end
            for (int j = 0; j < s; j++) begin
                applyStimulus(rb(), rb(), rb(), 1'b1, r4(), 4, k, 1'b0, 1'b0);
            end
            if (k == n - 1) begin
                applyStimulus(b_run, b_halt, rb(), 1'b0, r4(), 4, k, 1'b0, 1'b1);
                model_count++;
            end else begin
                applyStimulus(rb(), rb(), rb(), 1'b0, r4(), 4, k, 1'b0, 1'b0);
            end
        end
    endtask

    // HALT for a while, then release. The next cycle is T0.
    task automatic haltThenResume(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(rb(), 1'b1, rb(), rb(), r4(), 5, 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, rb(), rb(), r4(), 5, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, rb(), rb(), r4(), 5, 0, 1'b0, 1'b0);
    endtask

    // IDLE for a while, then run. The next cycle is T0.
    task automatic idleThenRun(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, rb(), rb(), r4(), 0, 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, rb(), rb(), r4(), 0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each sampled output word with the oldest expectation.
    // Any activity with nothing expected is also an error.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput($sformatf("seq%0d_phase%0d", e.seq, e.phase), dut_vec, e.vec);
            end else if (dut_vec !== '0) begin
                checkOutput("unexpected_activity", dut_vec, 23'(0));
            end
        end
    end

    initial begin
        int mode;
        compared    = 0;
        mismatched  = 0;
        model_count = 0;
        seq_no      = 0;
        Clear       = 1'b1;
        run         = 1'b0;
        halt_req    = 1'b0;
        mem_ready   = 1'b0;
        stall       = 1'b0;
        exec_len    = '0;
        #2;
        checkOutput("reset_async", dut_vec, 23'(0));
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkOutput("reset_held", dut_vec, 23'(0));
        Clear = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, SW'(0), 0, 0, 1'b0, 1'b0);
        doInstruction(0, 2, -1, 0, 1'b0, 1'b0, 1'b1);
        doInstruction(3, 1, -1, 0, 1'b0, 1'b0, 1'b1);
        doInstruction(0, 4, 2, 2, 1'b0, 1'b0, 1'b1);
        doInstruction(0, 3, -1, 0, 1'b0, 1'b1, 1'b1);
        haltThenResume(2);
        doInstruction(1, 0, -1, 0, 1'b0, 1'b0, 1'b1);
        doInstruction(0, 15, -1, 0, 1'b0, 1'b0, 1'b1);
        doInstruction(2, 8, -1, 0, 1'b0, 1'b0, 1'b0);
        idleThenRun(2);
        doInstruction(0, 1, 0, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(rb(), 1'b1, rb(), rb(), r4(), 0, 0, 1'b0, 1'b0);
        haltThenResume(1);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 4));
            case (mode)
                0, 1: doInstruction(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                    -1, 0, 1'b1, 1'b0, 1'b1);
                2: begin
                    doInstruction(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                  -1, 0, 1'b1, 1'b1, rb());
                    haltThenResume(int'($urandom_range(1, 3)));
                end
                3: begin
                    doInstruction(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                  -1, 0, 1'b1, 1'b0, 1'b0);
                    idleThenRun(int'($urandom_range(0, 3)));
                end
                default: begin
                    doInstruction(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                  -1, 0, 1'b1, 1'b0, 1'b0);
                    applyStimulus(rb(), 1'b1, rb(), rb(), r4(), 0, 0, 1'b0, 1'b0);
                    haltThenResume(int'($urandom_range(1, 2)));
                end
            endcase
        end

        applyStimulus(rb(), rb(), rb(), rb(), r4(), 1, 0, 1'b0, 1'b0);
        applyStimulus(rb(), rb(), 1'b1, rb(), r4(), 2, 0, 1'b1, 1'b0);
        applyStimulus(rb(), rb(), rb(), rb(), SW'(5), 3, 0, 1'b0, 1'b0);
        applyStimulus(rb(), rb(), rb(), 1'b0, r4(), 4, 0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        stall    = 1'b1;
        run      = 1'b1;
        halt_req = 1'b0;
        #2;
        Clear = 1'b1;
        #1;
        checkOutput("clear_mid_exec", dut_vec, 23'(0));
        model_count = 0;
        run = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("clear_held_exec", dut_vec, 23'(0));
        Clear = 1'b0;
        applyStimulus(1'b0, 1'b0, rb(), rb(), r4(), 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge Clock);
        checkOutput("queue_drain", 23'(exp_q.size()), 23'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
